// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults and types for the pixel datapath.
// Holds the default 800x600@72 Hz timing (50 MHz pixel clock), the raster
// coordinate type consumed by the colour generators, the RGB pixel type,
// the bundle of sync signals carried down the delay line, and the states
// of the optional pause sequencer (VGA_SCAN_PAUSE_EN).
package vga_pkg;

  localparam int HACTIVE = 800;
  localparam int HFP     = 56;
  localparam int HSYNC   = 120;
  localparam int HBP     = 64;
  localparam int VACTIVE = 600;
  localparam int VFP     = 37;
  localparam int VSYNC   = 6;
  localparam int VBP     = 23;
  localparam int HTOTAL  = HACTIVE + HFP + HSYNC + HBP;  // 1040
  localparam int VTOTAL  = VACTIVE + VFP + VSYNC + VBP;  // 666

  typedef logic signed [10:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Field order fixes the bit layout inside the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic sof;
  } sync_t;

  typedef enum logic [1:0] {
    SCAN_RUN    = 2'd0,
    SCAN_ARMED  = 2'd1,
    SCAN_PAUSED = 2'd2
  } scan_state_t;

  // Half-open window test lo <= v < hi, unsigned.
  function automatic logic in_window(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_sync_delay.sv
// sync_delay: LAT-deep, enable-gated shift register.
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous active-low reset; every stage loads rst_val
//   en       in   shift enable; all stages hold when low
//   din      in   W-bit stage-0 input
//   rst_val  in   W-bit value loaded into every stage on reset
//   dout     out  W-bit last stage
module sync_delay
  import vga_pkg::*;
#(
  parameter int LAT = 1,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic [W-1:0] rst_val,
  output logic [W-1:0] dout
);

  logic [LAT-1:0][W-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe <= {LAT{rst_val}};
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[LAT-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster scan controller for the pixel datapath.
// Produces spotX/spotY for the colour generators, plus hs/vs/blank/sof
// delayed LAT en-cycles so they line up with the generators' registered
// RGB, and a completed-frame counter.
// Ports:
//   clk        in   pixel clock
//   reset_n    in   synchronous active-low reset
//   en         in   advance enable; scan and delay line hold when low
//   pause_req  in   (only with VGA_SCAN_PAUSE_EN) stop at next frame boundary
//   spotX      out  current column, 0..HTOTAL-1
//   spotY      out  current line, 0..VTOTAL-1
//   hs, vs     out  syncs, active level H_POL / V_POL
//   blank      out  1 outside the active area
//   sof        out  pulse at pixel (0,0)
//   frame_cnt  out  completed-frame count, wraps
// Optional feature macro: VGA_SCAN_PAUSE_EN.
module vga_scan_ctrl #(
  parameter int HACTIVE = vga_pkg::HACTIVE,
  parameter int HFP     = vga_pkg::HFP,
  parameter int HSYNC   = vga_pkg::HSYNC,
  parameter int HBP     = vga_pkg::HBP,
  parameter int VACTIVE = vga_pkg::VACTIVE,
  parameter int VFP     = vga_pkg::VFP,
  parameter int VSYNC   = vga_pkg::VSYNC,
  parameter int VBP     = vga_pkg::VBP,
  parameter bit H_POL   = 1'b1,
  parameter bit V_POL   = 1'b1,
  parameter int LAT     = 1,
  parameter int FCW     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
`ifdef VGA_SCAN_PAUSE_EN
  input  logic                pause_req,
`endif
  output logic signed [10:0]  spotX,
  output logic signed [10:0]  spotY,
  output logic                hs,
  output logic                vs,
  output logic                blank,
  output logic                sof,
  output logic [FCW-1:0]      frame_cnt
);

  import vga_pkg::*;

  localparam int H_TOT = HACTIVE + HFP + HSYNC + HBP;
  localparam int V_TOT = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_BLK  = 11'(HACTIVE);
  localparam logic [10:0] V_BLK  = 11'(VACTIVE);
  localparam logic [10:0] H_SS   = 11'(HACTIVE + HFP);
  localparam logic [10:0] H_SE   = 11'(HACTIVE + HFP + HSYNC);
  localparam logic [10:0] V_SS   = 11'(VACTIVE + VFP);
  localparam logic [10:0] V_SE   = 11'(VACTIVE + VFP + VSYNC);

  localparam sync_t S_IDLE = '{hs: ~H_POL, vs: ~V_POL, blank: 1'b1, sof: 1'b0};

  if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_total
    $error("vga_scan_ctrl: HTOTAL/VTOTAL exceed 11-bit counter range");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("vga_scan_ctrl: LAT must be 1..4");
  end

  logic [10:0] hcnt, vcnt;
  logic        last_x, last_y, frame_end;
  logic        paused;
  sync_t       s0, s_out;

  assign last_x    = (hcnt == H_LAST);
  assign last_y    = (vcnt == V_LAST);
  assign frame_end = last_x && last_y;

`ifdef VGA_SCAN_PAUSE_EN
  // A request is remembered (ARMED) until the frame completes; the wrap
  // into (0,0) happens normally and the scan then parks there.
  scan_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= SCAN_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN_RUN:    if (pause_req) state_nxt = (en && frame_end) ? SCAN_PAUSED : SCAN_ARMED;
      SCAN_ARMED:  if (en && frame_end) state_nxt = SCAN_PAUSED;
      SCAN_PAUSED: if (en && !pause_req) state_nxt = SCAN_RUN;
      default:     state_nxt = SCAN_RUN;
    endcase
  end

  always_comb begin
    paused = (state == SCAN_PAUSED);
  end
`else
  assign paused = 1'b0;
`endif

  // Scan counters; frame_cnt counts completed frames at the (0,0) wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else if (en && !paused) begin
      if (last_x) begin
        hcnt <= '0;
        if (last_y) begin
          vcnt      <= '0;
          frame_cnt <= frame_cnt + FCW'(1);
        end else begin
          vcnt <= vcnt + 11'd1;
        end
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  // Stage-0 decode from the registered position. vcnt only changes at the
  // hcnt wrap, so vs edges land on line starts.
  always_comb begin
    s0.hs    = in_window(hcnt, H_SS, H_SE) ? H_POL : ~H_POL;
    s0.vs    = in_window(vcnt, V_SS, V_SE) ? V_POL : ~V_POL;
    s0.blank = (hcnt >= H_BLK) || (vcnt >= V_BLK);
    s0.sof   = (hcnt == 11'd0) && (vcnt == 11'd0);
    if (paused) s0 = S_IDLE;
  end

  sync_delay #(
    .LAT (LAT),
    .W   ($bits(sync_t))
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (s0),
    .rst_val (S_IDLE),
    .dout    (s_out)
  );

  assign spotX = $signed(hcnt);
  assign spotY = $signed(vcnt);
  assign hs    = s_out.hs;
  assign vs    = s_out.vs;
  assign blank = s_out.blank;
  assign sof   = s_out.sof;

endmodule
